cache_ctrl: RTL and testbench

//  Sequencing FSM for the direct-mapped instruction/data cache: detects misses from findhit,

---
 rtl/cache_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cache_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: miss/fill/flush sequencer for a direct-mapped, one-word-per-line cache.
// Optional hit/miss counters are enabled by defining CACHE_CTRL_PERF_EN.
module cache_ctrl #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int INDEX_WIDTH  = 4,
   parameter int OFFSET_WIDTH = 2
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic                  iReq,
   input  logic [ADDR_WIDTH-1:0] iAddress,
   input  logic                  iHit,
   input  logic                  iFlush,
   input  logic [ADDR_WIDTH-1:0] iFlushAddress,
   output logic                  oStall,
   output logic                  oMemReq,
   output logic [ADDR_WIDTH-1:0] oMemAddr,
   input  logic                  iMemAck,
   input  logic [DATA_WIDTH-1:0] iMainMemoryData,
   output logic                  oFillEn,
   output logic [INDEX_WIDTH-1:0] oFillIndex,
   output logic [ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH-1:0] oFillTag,
   output logic [DATA_WIDTH-1:0] oFillData,
   output logic                  oInvEn,
   output logic [INDEX_WIDTH-1:0] oInvIndex
`ifdef CACHE_CTRL_PERF_EN
   ,
   output logic [31:0]           oHitCount,
   output logic [31:0]           oMissCount
`endif
);

   localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int TAG_LSB   = OFFSET_WIDTH + INDEX_WIDTH;

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_MREQ,
      S_FILL,
      S_INV
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [INDEX_WIDTH-1:0] r_cnt;
   logic                   r_pend;
   logic [INDEX_WIDTH-1:0] r_flushIdx;
   logic [TAG_WIDTH-1:0]   r_missTag;
   logic [INDEX_WIDTH-1:0] r_missIdx;
   logic [DATA_WIDTH-1:0]  r_fillData;
   logic                   w_miss;
   logic                   w_flushNow;
   logic                   w_unused;

   assign w_miss     = iReq & ~iHit;
   assign w_flushNow = r_pend | iFlush;

   // Offset and tag bits of the flush address play no part in invalidation
   assign w_unused = ^{iAddress[OFFSET_WIDTH-1:0],
                       iFlushAddress[ADDR_WIDTH-1:TAG_LSB],
                       iFlushAddress[OFFSET_WIDTH-1:0]};

   assign oMemAddr   = {r_missTag, r_missIdx, {OFFSET_WIDTH{1'b0}}};
   assign oFillIndex = r_missIdx;
   assign oFillTag   = r_missTag;
   assign oFillData  = r_fillData;

   // State register plus sweep counter
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state <= S_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_INIT)
            r_cnt <= r_cnt + INDEX_WIDTH'(1);
      end
   end

   // Next-state and output decode
   always_comb begin
      w_next    = r_state;
      oStall    = 1'b1;
      oMemReq   = 1'b0;
      oFillEn   = 1'b0;
      oInvEn    = 1'b0;
      oInvIndex = r_flushIdx;
      case (r_state)
         S_INIT: begin
            oInvEn    = 1'b1;
            oInvIndex = r_cnt;
            if (r_cnt == {INDEX_WIDTH{1'b1}})
               w_next = S_IDLE;
         end
         S_IDLE: begin
            oStall = w_miss;
            if (w_flushNow)
               w_next = S_INV;
            else if (w_miss)
               w_next = S_MREQ;
         end
         S_MREQ: begin
            oMemReq = 1'b1;
            if (iMemAck)
               w_next = S_FILL;
         end
         S_FILL: begin
            oFillEn = 1'b1;
            w_next  = w_flushNow ? S_INV : S_IDLE;
         end
         S_INV: begin
            oInvEn = 1'b1;
            oStall = iReq;
            w_next = S_IDLE;
         end
         default: w_next = S_INIT;
      endcase
   end

   // Flush bookkeeping: one-deep pending flag, newest index wins
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_pend     <= 1'b0;
         r_flushIdx <= '0;
      end else begin
         if (iFlush)
            r_flushIdx <= iFlushAddress[OFFSET_WIDTH +: INDEX_WIDTH];
         if (iFlush && r_state != S_IDLE)
            r_pend <= 1'b1;
         else if (r_state == S_INV)
            r_pend <= 1'b0;
      end
   end

   // Miss address capture and fill data latch
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_missTag  <= '0;
         r_missIdx  <= '0;
         r_fillData <= '0;
      end else begin
         if (r_state == S_IDLE && w_next == S_MREQ) begin
            r_missTag <= iAddress[TAG_LSB +: TAG_WIDTH];
            r_missIdx <= iAddress[OFFSET_WIDTH +: INDEX_WIDTH];
         end
         if (r_state == S_MREQ && iMemAck)
            r_fillData <= iMainMemoryData;
      end
   end

`ifdef CACHE_CTRL_PERF_EN
   logic [31:0] r_hitCnt;
   logic [31:0] r_missCnt;

   // Saturating hit/miss counters
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_hitCnt  <= '0;
         r_missCnt <= '0;
      end else if (r_state == S_IDLE) begin
         if (iReq && iHit && r_hitCnt != 32'hFFFF_FFFF)
            r_hitCnt <= r_hitCnt + 32'd1;
         if (w_next == S_MREQ && r_missCnt != 32'hFFFF_FFFF)
            r_missCnt <= r_missCnt + 32'd1;
      end
   end

   assign oHitCount  = r_hitCnt;
   assign oMissCount = r_missCnt;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: scoreboard bench for cache_ctrl.
// Define CACHE_CTRL_PERF_EN to also check the hit/miss counters.
module tb_cache_ctrl;

   logic        clk = 1'b0;
   logic        iRst, iReq, iHit, iFlush, iMemAck;
   logic [31:0] iAddress, iFlushAddress, iMainMemoryData;
   logic        oStall, oMemReq, oFillEn, oInvEn;
   logic [31:0] oMemAddr, oFillData;
   logic [3:0]  oFillIndex, oInvIndex;
   logic [25:0] oFillTag;
`ifdef CACHE_CTRL_PERF_EN
   logic [31:0] oHitCount, oMissCount;
`endif

   always #5 clk = ~clk;

   cache_ctrl dut (
      .iClk(clk), .iRst(iRst), .iReq(iReq), .iAddress(iAddress),
      .iHit(iHit), .iFlush(iFlush), .iFlushAddress(iFlushAddress),
      .oStall(oStall), .oMemReq(oMemReq), .oMemAddr(oMemAddr),
      .iMemAck(iMemAck), .iMainMemoryData(iMainMemoryData),
      .oFillEn(oFillEn), .oFillIndex(oFillIndex), .oFillTag(oFillTag),
      .oFillData(oFillData), .oInvEn(oInvEn), .oInvIndex(oInvIndex)
`ifdef CACHE_CTRL_PERF_EN
      , .oHitCount(oHitCount), .oMissCount(oMissCount)
`endif
   );

   typedef struct {
      logic [3:0]  idx;
      logic [25:0] tag;
      logic [31:0] data;
   } fill_t;

   int          n_cmp = 0;
   int          n_err = 0;
   int          exp_hits = 0;
   int          exp_miss = 0;
   logic [3:0]  q_inv[$];
   fill_t       q_fill[$];
   logic [31:0] q_mreq[$];
   logic        mon_on = 1'b0;
   logic        prev_req = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic unexp(input string nm, input logic [31:0] act);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got event value %h required no event", nm, act);
   endtask

   // Monitor: pops the expected response whenever the DUT presents one
   always @(negedge clk) begin
      if (mon_on) begin
         if (oInvEn && oFillEn)
            unexp("inv_fill_overlap", 32'(oFillIndex));
         if (oInvEn) begin
            if (q_inv.size() == 0) unexp("unexp_inv", 32'(oInvIndex));
            else chk("inv_idx", 32'(oInvIndex), 32'(q_inv.pop_front()));
         end
         if (oFillEn) begin
            if (q_fill.size() == 0) unexp("unexp_fill", oFillData);
            else begin
               fill_t f;
               f = q_fill.pop_front();
               chk("fill_idx", 32'(oFillIndex), 32'(f.idx));
               chk("fill_tag", 32'(oFillTag), 32'(f.tag));
               chk("fill_data", oFillData, f.data);
            end
         end
         if (oMemReq && !prev_req) begin
            if (q_mreq.size() == 0) unexp("unexp_mreq", oMemAddr);
            else chk("mem_addr", oMemAddr, q_mreq.pop_front());
         end
         prev_req = oMemReq;
      end
   end

   // mode 0: plain miss; 1: flush in first MREQ cycle; 2: flush with miss in IDLE
   task automatic miss(input logic [31:0] addr, input logic [3:0] eidx,
                       input logic [25:0] etag, input logic [31:0] eaddr,
                       input int ack_after, input logic [31:0] data,
                       input int mode, input logic [31:0] faddr,
                       input logic [3:0] fidx, input int exp_st);
      int   st = 0;
      int   mc = 0;
      logic filled = 1'b0;
      logic done = 1'b0;
      fill_t f;
      f.idx = eidx; f.tag = etag; f.data = data;
      q_mreq.push_back(eaddr);
      if (mode != 0) q_inv.push_back(fidx);
      q_fill.push_back(f);
      iReq = 1'b1;
      iAddress = addr;
      for (int c = 0; c < 30 && !done; c++) begin
         iHit = filled;
         iFlush = 1'b0;
         iMemAck = 1'b0;
         if (mode == 2 && c == 0) begin
            iFlush = 1'b1;
            iFlushAddress = faddr;
         end
         if (oMemReq && c > 0) begin
            if (mc == ack_after - 1) begin
               iMemAck = 1'b1;
               iMainMemoryData = data;
            end
            if (mode == 1 && mc == 0) begin
               iFlush = 1'b1;
               iFlushAddress = faddr;
            end
            mc++;
         end
         @(negedge clk);
         if (oStall) st++;
         if (oFillEn) filled = 1'b1;
         done = !oStall || (mode == 1 && oInvEn);
         @(posedge clk);
         #1;
      end
      iReq = 1'b0; iHit = 1'b0; iFlush = 1'b0; iMemAck = 1'b0;
      chk("miss_done", 32'(done), 32'd1);
      chk("miss_stall_cycles", 32'(st), 32'(exp_st));
      exp_miss++;
      if (mode != 1) exp_hits++;
   endtask

   initial begin
      logic        got;
      logic [31:0] hit_addr [3];
      hit_addr[0] = 32'h0000_0040;
      hit_addr[1] = 32'h0000_0080;
      hit_addr[2] = 32'h0000_0044;
      iRst = 1'b1; iReq = 1'b0; iHit = 1'b0; iFlush = 1'b0; iMemAck = 1'b0;
      iAddress = '0; iFlushAddress = '0; iMainMemoryData = '0;
      for (int i = 0; i < 16; i++) q_inv.push_back(4'(i));
      @(posedge clk);
      mon_on = 1'b1;
      #1 iRst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("sweep_stall", 32'(oStall), 32'd1);
         chk("sweep_memreq", 32'(oMemReq), 32'd0);
         @(posedge clk);
         #1;
      end
`ifdef CACHE_CTRL_PERF_EN
      chk("hitcnt_reset", oHitCount, 32'd0);
      chk("misscnt_reset", oMissCount, 32'd0);
`endif
      for (int i = 0; i < 3; i++) begin
         iReq = 1'b1; iHit = 1'b1; iAddress = hit_addr[i];
         @(negedge clk);
         chk("hit_stall", 32'(oStall), 32'd0);
         chk("hit_memreq", 32'(oMemReq), 32'd0);
         @(posedge clk);
         #1;
         exp_hits++;
      end
      iReq = 1'b0; iHit = 1'b0;
      @(posedge clk);
      #1;
      miss(32'h1234_5678, 4'hE, 26'h048D159, 32'h1234_5678, 3,
           32'hDEAD_BEEF, 0, 32'h0, 4'h0, 5);
      miss(32'h0000_00A4, 4'h9, 26'h0000002, 32'h0000_00A4, 1,
           32'h0BAD_F00D, 0, 32'h0, 4'h0, 3);
      miss(32'h0000_1238, 4'hE, 26'h0000048, 32'h0000_1238, 2,
           32'hCAFE_0001, 1, 32'h0000_0038, 4'hE, 5);
      miss(32'h0000_0F08, 4'h2, 26'h000003C, 32'h0000_0F08, 1,
           32'h1357_9BDF, 2, 32'h0000_0014, 4'h5, 5);
      @(posedge clk);
      #1;
`ifdef CACHE_CTRL_PERF_EN
      chk("hitcnt", oHitCount, 32'(exp_hits));
      chk("misscnt", oMissCount, 32'(exp_miss));
`endif
      iReq = 1'b1; iHit = 1'b0; iAddress = 32'h0000_0100;
      q_mreq.push_back(32'h0000_0100);
      got = 1'b0;
      for (int c = 0; c < 5 && !got; c++) begin
         @(posedge clk);
         #1;
         if (oMemReq) got = 1'b1;
      end
      chk("rst_mreq_seen", 32'(got), 32'd1);
      for (int i = 0; i < 16; i++) q_inv.push_back(4'(i));
      iRst = 1'b1;
      iReq = 1'b0;
      @(posedge clk);
      #1;
      iRst = 1'b0;
      iMemAck = 1'b1;
      iMainMemoryData = 32'hFFFF_0000;
      @(negedge clk);
      chk("rst_memreq_drop", 32'(oMemReq), 32'd0);
      chk("rst_stall", 32'(oStall), 32'd1);
      @(posedge clk);
      #1 iMemAck = 1'b0;
      repeat (17) @(posedge clk);
      #1;
      chk("rst_back_idle_stall", 32'(oStall), 32'd0);
`ifdef CACHE_CTRL_PERF_EN
      chk("hitcnt_rst", oHitCount, 32'd0);
      chk("misscnt_rst", oMissCount, 32'd0);
`endif
      repeat (2) @(posedge clk);
      chk("inv_left", 32'(q_inv.size()), 32'd0);
      chk("fill_left", 32'(q_fill.size()), 32'd0);
      chk("mreq_left", 32'(q_mreq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
